// File: rtl/cv32e40s_pkg.sv
// rtl/cv32e40s_pkg.sv - shared types and limits for the instruction transaction adapter
//
// Purpose: state encoding of the address-phase adapter and the upper bound on
// the number of outstanding instruction transactions.
package cv32e40s_pkg;

  typedef enum logic {
    TRANS_TRANSPARENT,
    TRANS_REGISTERED
  } trans_adapter_state_e;

  localparam int unsigned MAX_OUTSTANDING_LIMIT = 4;

endpackage

// File: rtl/cv32e40s_instr_trans_adapter.sv
// rtl/cv32e40s_instr_trans_adapter.sv - prefetcher-to-OBI instruction transaction adapter
//
// Purpose: gives the OBI address phase a stable address, limits and counts
// outstanding transactions, tags each with its pointer-access flag and drops
// responses of transactions that were killed.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   trans_valid_i/ready_o/addr_i    prefetcher request handshake and address
//   trans_ptr_access_i              request is a pointer fetch
//   kill_i                          discard responses of all older transactions
//   resp_valid_o/rdata_o/err_o      live response towards fetch (no backpressure)
//   resp_ptr_access_o               pointer flag of the answered transaction
//   outstanding_o                   accepted-but-unanswered count
//   obi_req_o/gnt_i/addr_o          OBI address phase
//   obi_rvalid_i/rdata_i/err_i      OBI response phase
module cv32e40s_instr_trans_adapter
  import cv32e40s_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trans_valid_i,
  output logic        trans_ready_o,
  input  logic [31:0] trans_addr_i,
  input  logic        trans_ptr_access_i,
  input  logic        kill_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        resp_ptr_access_o,
  output logic [2:0]  outstanding_o,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [2:0]       MAX_CNT  = 3'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(MAX_OUTSTANDING - 1);

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > MAX_OUTSTANDING_LIMIT) begin : g_bad_param
    $error("MAX_OUTSTANDING out of range");
  end

  trans_adapter_state_e       state_q;
  logic [31:0]                addr_q;
  logic [2:0]                 cnt_q;
  logic [2:0]                 cnt_d;
  logic [2:0]                 discard_q;
  logic [2:0]                 discard_d;
  logic [MAX_OUTSTANDING-1:0] flag_q;
  logic [PTR_W-1:0]           wptr_q;
  logic [PTR_W-1:0]           rptr_q;
  logic                       can_issue;
  logic                       accept;

  // A response arriving this cycle does not free a slot: no bypass path.
  assign can_issue = cnt_q < MAX_CNT;

  always_comb begin
    obi_req_o     = 1'b0;
    obi_addr_o    = trans_addr_i;
    trans_ready_o = 1'b0;
    case (state_q)
      TRANS_TRANSPARENT: begin
        obi_req_o     = trans_valid_i && can_issue;
        obi_addr_o    = trans_addr_i;
        trans_ready_o = can_issue;
      end
      TRANS_REGISTERED: begin
        // Parked request: already accepted, held until granted, never retracted.
        obi_req_o     = 1'b1;
        obi_addr_o    = addr_q;
        trans_ready_o = 1'b0;
      end
      default: ;
    endcase
  end

  assign accept = trans_valid_i && trans_ready_o;

  assign resp_valid_o      = obi_rvalid_i && (discard_q == 3'd0) && !kill_i;
  assign resp_rdata_o      = obi_rdata_i;
  assign resp_err_o        = obi_err_i;
  assign resp_ptr_access_o = flag_q[rptr_q];
  assign outstanding_o     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, obi_rvalid_i})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Kill covers every transaction accepted before this cycle, including one
  // still parked; the one answered in the kill cycle is already gone.
  always_comb begin
    discard_d = discard_q;
    if (kill_i) begin
      discard_d = cnt_q - {2'b00, obi_rvalid_i};
    end else if (obi_rvalid_i && (discard_q != 3'd0)) begin
      discard_d = discard_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TRANS_TRANSPARENT;
      addr_q  <= 32'h0;
    end else begin
      case (state_q)
        TRANS_TRANSPARENT: begin
          if (obi_req_o && !obi_gnt_i) begin
            addr_q  <= trans_addr_i;
            state_q <= TRANS_REGISTERED;
          end
        end
        TRANS_REGISTERED: begin
          if (obi_gnt_i) begin
            state_q <= TRANS_TRANSPARENT;
          end
        end
        default: state_q <= TRANS_TRANSPARENT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 3'd0;
      discard_q <= 3'd0;
    end else begin
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
    end
  end

  // Pointer-flag FIFO: pushed on accept, popped on every response (live or dropped).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (accept) begin
        flag_q[wptr_q] <= trans_ptr_access_i;
        wptr_q         <= (wptr_q == LAST_IDX) ? '0 : wptr_q + 1'b1;
      end
      if (obi_rvalid_i) begin
        rptr_q <= (rptr_q == LAST_IDX) ? '0 : rptr_q + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  a_no_rvalid_idle: assert property (@(posedge clk) disable iff (!rst_n)
    obi_rvalid_i |-> (cnt_q != 3'd0));
  a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= MAX_CNT);
  a_discard_le_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    discard_q <= cnt_q);
  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (obi_req_o && !obi_gnt_i) |=> (obi_req_o && (obi_addr_o == $past(obi_addr_o))));
`endif

endmodule

// File: tb/tb_cv32e40s_instr_trans_adapter.sv
// tb/tb_cv32e40s_instr_trans_adapter.sv - scoreboard bench for the instruction transaction adapter
module tb_cv32e40s_instr_trans_adapter;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trans_valid_i;
  logic        trans_ready_o;
  logic [31:0] trans_addr_i;
  logic        trans_ptr_access_i;
  logic        kill_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        resp_ptr_access_o;
  logic [2:0]  outstanding_o;
  logic        obi_req_o;
  logic        obi_gnt_i;
  logic [31:0] obi_addr_o;
  logic        obi_rvalid_i;
  logic [31:0] obi_rdata_i;
  logic        obi_err_i;

  cv32e40s_instr_trans_adapter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .trans_valid_i(trans_valid_i), .trans_ready_o(trans_ready_o),
    .trans_addr_i(trans_addr_i), .trans_ptr_access_i(trans_ptr_access_i),
    .kill_i(kill_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o), .resp_ptr_access_o(resp_ptr_access_o),
    .outstanding_o(outstanding_o),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic ptr; logic live; } txn_t;
  typedef struct packed { logic [31:0] rdata; logic err; logic ptr; } exp_t;

  txn_t        model_q[$];   // accepted, unanswered, in order
  logic [31:0] acc_q[$];     // accepted, not yet granted
  int          slave_q[$];   // granted, unanswered (count only)
  exp_t        exp_q[$];     // live responses fetch must see

  int          checks = 0;
  int          failures = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_addr = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every live response must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata_o, e.rdata);
        chk("resp_err", {31'd0, resp_err_o}, {31'd0, e.err});
        chk("resp_ptr", {31'd0, resp_ptr_access_o}, {31'd0, e.ptr});
      end
    end
  end

  // One bus cycle; entered and left at posedge+1.
  task automatic cycle(input bit tv, input logic [31:0] a, input bit p,
                       input bit k, input bit g, input bit rv);
    bit acc;
    trans_valid_i      = tv;
    trans_addr_i       = a;
    trans_ptr_access_i = p;
    kill_i             = k;
    obi_gnt_i          = g;
    obi_rdata_i        = $urandom;
    obi_err_i          = 1'($urandom_range(0, 1));
    obi_rvalid_i       = 1'b0;
    if (rv && slave_q.size() > 0) begin
      void'(slave_q.pop_front());
      obi_rvalid_i = 1'b1;
      if (model_q[0].live && !k)
        exp_q.push_back('{rdata: obi_rdata_i, err: obi_err_i, ptr: model_q[0].ptr});
    end
    @(negedge clk);
    chk("outstanding", {29'd0, outstanding_o}, model_q.size());
    if (acc_q.size() > 0) begin
      chk("parked_req", {31'd0, obi_req_o}, 32'd1);
      chk("parked_addr", obi_addr_o, acc_q[0]);
      chk("parked_ready", {31'd0, trans_ready_o}, 32'd0);
    end else begin
      chk("ready", {31'd0, trans_ready_o}, (model_q.size() < MAX) ? 32'd1 : 32'd0);
      if (model_q.size() >= MAX)
        chk("full_req", {31'd0, obi_req_o}, 32'd0);
    end
    if (hold_v) begin
      chk("hold_req", {31'd0, obi_req_o}, 32'd1);
      chk("hold_addr", obi_addr_o, hold_addr);
    end
    // Model update: answer, then kill of older ones, then this cycle's accept.
    if (obi_rvalid_i) void'(model_q.pop_front());
    if (k) foreach (model_q[i]) model_q[i].live = 1'b0;
    acc = tv && trans_ready_o;
    if (acc) begin
      model_q.push_back('{ptr: p, live: 1'b1});
      acc_q.push_back(a);
    end
    if (obi_req_o && obi_gnt_i) begin
      if (acc_q.size() == 0) begin
        chk("gnt_without_accept", 32'd1, 32'd0);
      end else begin
        chk("gnt_addr", obi_addr_o, acc_q[0]);
        void'(acc_q.pop_front());
        slave_q.push_back(1);
      end
    end
    hold_v    = obi_req_o && !obi_gnt_i;
    hold_addr = obi_addr_o;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((model_q.size() > 0 || acc_q.size() > 0) && n < 60) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      n++;
    end
    chk("drain_timeout", (n < 60) ? 32'd0 : 32'd1, 32'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("exp_left", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    trans_valid_i = 1'b0;
    kill_i        = 1'b0;
    obi_gnt_i     = 1'b0;
    obi_rvalid_i  = 1'b0;
    #1;
    chk("rst_outstanding", {29'd0, outstanding_o}, 32'd0);
    chk("rst_req", {31'd0, obi_req_o}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_ready", {31'd0, trans_ready_o}, 32'd1);
    model_q.delete();
    acc_q.delete();
    slave_q.delete();
    exp_q.delete();
    hold_v = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    trans_addr_i       = 32'h0;
    trans_ptr_access_i = 1'b0;
    obi_rdata_i        = 32'h0;
    obi_err_i          = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Back-to-back fetches, immediate grant, 1-cycle response.
    cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // Grant withheld while the prefetcher changes its address.
    cycle(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    // Two outstanding, then a kill with a branch target presented.
    cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'h400, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 32'h400, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // Kill while a request is parked.
    cycle(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    // Pointer flag tagging.
    cycle(1'b1, 32'h800, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'h804, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // Randomized traffic with a reset in the middle of a burst.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cycle(1'($urandom_range(0, 3) != 0), {$urandom_range(0, 32'h3fff), 2'b00},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
